mfp_uart_transmitter: RTL

// - 8N1 UART transmitter; the outbound counterpart to the system UART receiver.
// - Drives the board UART TX pin from a small write FIFO.
// - Filled by a one-cycle write strobe from the AHB-Lite UART register slave.
// - Software can queue several bytes without polling per bit.

---
 rtl/mfp_uart_transmitter_pkg.sv | 25 ++
 rtl/mfp_uart_transmitter_if.sv | 28 ++
 rtl/mfp_uart_tx_fifo.sv | 61 ++++++
 rtl/mfp_uart_transmitter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared definitions for the MFP UART transmitter: FSM state encoding,
// default line settings and the clocks-per-bit rounding helper.
package mfp_uart_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;
  localparam int DATA_BITS         = 8;

  // Rounded to the nearest whole clock so the receiver computes the same value.
  function automatic int calc_divisor(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  function automatic int counter_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/mfp_uart_transmitter_if.sv
// Write-side interface of the UART transmitter: byte strobe in, FIFO and
// activity status out.
interface mfp_uart_transmitter_if;
  import mfp_uart_transmitter_pkg::*;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 busy;

  modport master (
    output wr_en,
    output wr_data,
    input  fifo_full,
    input  fifo_empty,
    input  busy
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output fifo_full,
    output fifo_empty,
    output busy
  );

endinterface

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous-write register-array FIFO with extra-MSB pointers; flags are
// derived from the registered pointers.
module mfp_uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push_ok;
  logic                  pop_ok;

  assign full_o  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  // A write into a full FIFO only lands when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter: FIFO-fed frame sequencer with a registered TX line;
// consecutive queued bytes go out back-to-back with no idle gap.
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLK_FREQ        = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   resetn,
  mfp_uart_transmitter_if.slave  bus,
  output logic                   tx
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W   = counter_width(DIVISOR);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic                 bit_done;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  mfp_uart_tx_fifo #(
    .DATA_WIDTH (DATA_BITS),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (bus.wr_en),
    .pop_i   (fifo_pop),
    .data_i  (bus.wr_data),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_done       = (baud_cnt_q == CNT_W'(DIVISOR - 1));
  assign tx             = tx_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;

  // tx_d is the level the line takes on entering the next bit, so every
  // line bit starts exactly on a state or bit boundary.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = ST_START;
          tx_d     = 1'b0;
        end
      end

      ST_START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = ST_DATA;
          tx_d       = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end

      ST_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = ST_START;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        baud_cnt_d = '0;
        state_d    = ST_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule
